// File: rtl/cacheline_burst_adaptor.sv
// Cache-line to memory-burst bridge. It moves one LLC line as BEATS memory
// beats and can evict a line, fill a line, or write back and then fill.
module cacheline_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [ADDR_W-1:0]  wb_address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  output logic               busy_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              fill_pending;
  logic [LINE_W-1:0] line_buf;
  logic [ADDR_W-1:0] fill_addr;
  logic [ADDR_W-1:0] wb_addr;
  logic              accept;
  logic              last_beat;

  assign accept    = (state == IDLE) && (read_i || write_i);
  assign last_beat = resp_i && (cnt == CNT_W'(BEATS - 1));

  // Sequencing: write-back always goes first, the fill follows it directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      fill_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            state        <= WB;
            fill_pending <= read_i;
            cnt          <= '0;
          end else if (read_i) begin
            state        <= FILL;
            fill_pending <= 1'b0;
            cnt          <= '0;
          end
        end
        WB: begin
          if (last_beat) begin
            cnt          <= '0;
            state        <= fill_pending ? FILL : DONE;
            fill_pending <= 1'b0;
          end else if (resp_i) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FILL: begin
          if (last_beat) begin
            cnt   <= '0;
            state <= DONE;
          end else if (resp_i) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the request payload once so later input changes cannot leak into the burst.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf  <= line_i;
      fill_addr <= address_i;
      wb_addr   <= wb_address_i;
    end
  end

  // Assemble the filled line beat by beat; it holds between fills.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_o <= '0;
    end else if ((state == FILL) && resp_i) begin
      line_o[cnt*BURST_W +: BURST_W] <= burst_i;
    end
  end

  // Memory-side and LLC-side outputs decoded from the state, so reset clears them at once.
  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    burst_o   = '0;
    address_o = '0;
    busy_o    = (state != IDLE);
    case (state)
      WB: begin
        write_o   = 1'b1;
        burst_o   = line_buf[cnt*BURST_W +: BURST_W];
        address_o = {wb_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
      FILL: begin
        read_o    = 1'b1;
        address_o = {fill_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
      DONE: resp_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: the default 256/64 instance plus
// a 512/128 instance and a 256/32 instance for the width sweep.
module tb_cacheline_burst_adaptor;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Main instance, LINE_W=256, BURST_W=64.
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, wb_address_i, address_o;
  logic         read_i, write_i, resp_o, busy_o, read_o, write_o, resp_i;
  logic [63:0]  burst_i, burst_o;

  cacheline_burst_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .wb_address_i(wb_address_i), .read_i(read_i),
    .write_i(write_i), .resp_o(resp_o), .busy_o(busy_o), .burst_i(burst_i),
    .burst_o(burst_o), .address_o(address_o), .read_o(read_o),
    .write_o(write_o), .resp_i(resp_i)
  );

  // Sweep instance, LINE_W=512, BURST_W=128.
  logic [511:0] w_line_i, w_line_o;
  logic [31:0]  w_addr_i, w_wb_addr_i, w_addr_o;
  logic         w_rd_i, w_wr_i, w_resp_o, w_busy_o, w_rd_o, w_wr_o, w_resp_i;
  logic [127:0] w_burst_i, w_burst_o;

  cacheline_burst_adaptor #(.LINE_W(512), .BURST_W(128), .ADDR_W(32)) dut_w (
    .clk(clk), .reset_n(reset_n), .line_i(w_line_i), .line_o(w_line_o),
    .address_i(w_addr_i), .wb_address_i(w_wb_addr_i), .read_i(w_rd_i),
    .write_i(w_wr_i), .resp_o(w_resp_o), .busy_o(w_busy_o), .burst_i(w_burst_i),
    .burst_o(w_burst_o), .address_o(w_addr_o), .read_o(w_rd_o),
    .write_o(w_wr_o), .resp_i(w_resp_i)
  );

  // Sweep instance, LINE_W=256, BURST_W=32.
  logic [255:0] n_line_i, n_line_o;
  logic [31:0]  n_addr_i, n_wb_addr_i, n_addr_o;
  logic         n_rd_i, n_wr_i, n_resp_o, n_busy_o, n_rd_o, n_wr_o, n_resp_i;
  logic [31:0]  n_burst_i, n_burst_o;

  cacheline_burst_adaptor #(.LINE_W(256), .BURST_W(32), .ADDR_W(32)) dut_n (
    .clk(clk), .reset_n(reset_n), .line_i(n_line_i), .line_o(n_line_o),
    .address_i(n_addr_i), .wb_address_i(n_wb_addr_i), .read_i(n_rd_i),
    .write_i(n_wr_i), .resp_o(n_resp_o), .busy_o(n_busy_o), .burst_i(n_burst_i),
    .burst_o(n_burst_o), .address_o(n_addr_o), .read_o(n_rd_o),
    .write_o(n_wr_o), .resp_i(n_resp_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction observations collected by run().
  logic [63:0]  fill_beats [4];
  logic [255:0] exp_wb_line;
  logic [255:0] line_at_done;
  logic [31:0]  wb_addr_seen, rd_addr_seen;
  int  n_wr, n_rd, n_both, n_resp, resp_cyc, wbeat, rbeat, bad_step;
  logic gap_rd, post_resp, post_busy, done;

  // Drives one LLC request on the main instance; resp_i answers every
  // period-th active cycle. With flip set the LLC-side inputs toggle every cycle.
  task automatic run(input logic rd, input logic wr, input int period, input bit flip);
    int   cyc, wait_cnt;
    logic pend_gap;
    n_wr = 0; n_rd = 0; n_both = 0; n_resp = 0; resp_cyc = 0;
    wbeat = 0; rbeat = 0; bad_step = 0; gap_rd = 0; done = 0;
    wait_cnt = 0; pend_gap = 0;
    exp_wb_line = line_i;
    read_i = rd; write_i = wr; resp_i = 0;
    @(posedge clk);
    cyc = 1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (write_o) n_wr++;
      if (read_o) n_rd++;
      if (write_o && read_o) n_both++;
      if (pend_gap) begin
        gap_rd   = read_o && !write_o;
        pend_gap = 0;
      end
      if (write_o) begin
        if (burst_o !== exp_wb_line[wbeat*64 +: 64]) bad_step++;
      end else if (burst_o !== 64'h0) begin
        bad_step++;
      end
      if (resp_o) begin
        n_resp++;
        resp_cyc = cyc;
        line_at_done = line_o;
        done = 1;
        read_i = 0; write_i = 0; resp_i = 0;
      end else begin
        if (read_o || write_o) wait_cnt++;
        resp_i = (read_o || write_o) && (wait_cnt % period == 0);
        if (write_o && resp_i) begin
          wb_addr_seen = address_o;
          wbeat++;
          if (wbeat == 4) pend_gap = 1;
        end
        if (read_o && resp_i) begin
          rd_addr_seen = address_o;
          burst_i = fill_beats[rbeat];
          rbeat++;
        end
        if (flip) begin
          line_i = ~line_i; address_i = ~address_i; wb_address_i = ~wb_address_i;
        end
      end
    end
    check("timeout", done, 1'b1);
    @(negedge clk);
    post_resp = resp_o;
    post_busy = busy_o;
  endtask

  logic [255:0] line_t1;
  logic [511:0] exp512;
  logic [127:0] wbeats [4];
  logic [255:0] exp256;

  initial begin
    reset_n = 0;
    line_i = '0; address_i = '0; wb_address_i = '0; read_i = 0; write_i = 0;
    resp_i = 0; burst_i = '0;
    w_line_i = '0; w_addr_i = '0; w_wb_addr_i = '0; w_rd_i = 0; w_wr_i = 0;
    w_resp_i = 0; w_burst_i = '0;
    n_line_i = '0; n_addr_i = '0; n_wb_addr_i = '0; n_rd_i = 0; n_wr_i = 0;
    n_resp_i = 0; n_burst_i = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_rw", {read_o, write_o, resp_o}, 3'b000);
    check("rst_line", line_o, 256'h0);
    check("rst_addr_burst", {address_o, burst_o}, 96'h0);
    reset_n = 1;
    @(negedge clk);

    // Fill, resp_i every cycle.
    fill_beats[0] = 64'hAAAA_0000_0000_000A;
    fill_beats[1] = 64'hBBBB_0000_0000_000B;
    fill_beats[2] = 64'hCCCC_0000_0000_000C;
    fill_beats[3] = 64'hDDDD_0000_0000_000D;
    address_i = 32'h1234_5678;
    run(1'b1, 1'b0, 1, 1'b0);
    line_t1 = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
               64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    check("fill_rd_cycles", n_rd, 4);
    check("fill_no_write", n_wr, 0);
    check("fill_addr", rd_addr_seen, 32'h1234_5660);
    check("fill_resp_cycle", resp_cyc, 6);
    check("fill_line", line_at_done, line_t1);
    check("fill_resp_pulse", {post_resp, post_busy}, 2'b00);

    // Evict with resp_i in one of three cycles.
    line_i = {64'h3333_3333_0000_0003, 64'h2222_2222_0000_0002,
              64'h1111_1111_0000_0001, 64'h0F0F_0F0F_0000_0000};
    wb_address_i = 32'h4000_1234;
    run(1'b0, 1'b1, 3, 1'b0);
    check("evict_wr_cycles", n_wr, 12);
    check("evict_no_read", n_rd, 0);
    check("evict_beats", wbeat, 4);
    check("evict_burst_steps", bad_step, 0);
    check("evict_addr", wb_addr_seen, 32'h4000_1220);
    check("evict_resp_cycle", resp_cyc, 14);
    check("evict_line_kept", line_o, line_t1);

    // Combined write-back then fill, LLC inputs toggling during the transfer.
    line_i = {64'h8888_0000_0000_0044, 64'h8888_0000_0000_0033,
              64'h8888_0000_0000_0022, 64'h8888_0000_0000_0011};
    wb_address_i = 32'h8000_0040;
    address_i    = 32'h9000_0000;
    fill_beats[0] = 64'h9000_0000_0000_0001;
    fill_beats[1] = 64'h9000_0000_0000_0002;
    fill_beats[2] = 64'h9000_0000_0000_0003;
    fill_beats[3] = 64'h9000_0000_0000_0004;
    run(1'b1, 1'b1, 1, 1'b1);
    check("comb_wr_cycles", n_wr, 4);
    check("comb_rd_cycles", n_rd, 4);
    check("comb_never_both", n_both, 0);
    check("comb_read_after_wb", gap_rd, 1'b1);
    check("comb_burst_latched", bad_step, 0);
    check("comb_wb_addr", wb_addr_seen, 32'h8000_0040);
    check("comb_rd_addr", rd_addr_seen, 32'h9000_0000);
    check("comb_single_resp", n_resp, 1);
    check("comb_resp_cycle", resp_cyc, 10);
    check("comb_line", line_at_done, {64'h9000_0000_0000_0004, 64'h9000_0000_0000_0003,
                                      64'h9000_0000_0000_0002, 64'h9000_0000_0000_0001});

    // Asynchronous reset in the middle of a fill.
    address_i = 32'h0000_0100;
    read_i = 1;
    @(posedge clk);
    @(negedge clk);
    resp_i = 1; burst_i = 64'h5555_0000_0000_0001;
    @(negedge clk);
    check("mid_fill_beat1", line_o[63:0], 64'h5555_0000_0000_0001);
    resp_i = 1; burst_i = 64'h5555_0000_0000_0002;
    #2 reset_n = 0;
    #1;
    check("arst_rw", {read_o, write_o, resp_o, busy_o}, 4'b0000);
    check("arst_line", line_o, 256'h0);
    check("arst_addr", address_o, 32'h0);
    read_i = 0; resp_i = 0;
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    fill_beats[0] = 64'h6666_0000_0000_0001;
    fill_beats[1] = 64'h6666_0000_0000_0002;
    fill_beats[2] = 64'h6666_0000_0000_0003;
    fill_beats[3] = 64'h6666_0000_0000_0004;
    run(1'b1, 1'b0, 2, 1'b0);
    check("post_rst_rd_cycles", n_rd, 8);
    check("post_rst_addr", rd_addr_seen, 32'h0000_0100);
    check("post_rst_line", line_at_done, {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
                                          64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001});

    // Spurious memory acknowledges while idle.
    resp_i = 1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(negedge clk);
    check("idle_resp_busy", {busy_o, read_o, write_o, resp_o}, 4'b0000);
    check("idle_resp_line", line_o, {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
                                     64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001});
    check("idle_addr", address_o, 32'h0);
    resp_i = 0;

    // 512/128 fill: 6-bit alignment and beat ordering.
    wbeats[0] = 128'h1000_0000_0000_0000_0000_0000_0000_00A0;
    wbeats[1] = 128'h2000_0000_0000_0000_0000_0000_0000_00A1;
    wbeats[2] = 128'h3000_0000_0000_0000_0000_0000_0000_00A2;
    wbeats[3] = 128'h4000_0000_0000_0000_0000_0000_0000_00A3;
    exp512 = {wbeats[3], wbeats[2], wbeats[1], wbeats[0]};
    w_addr_i = 32'hABCD_EF7F;
    w_rd_i = 1;
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == 0) check("w512_addr", w_addr_o, 32'hABCD_EF40);
      w_resp_i = 1; w_burst_i = wbeats[b];
    end
    @(negedge clk);
    w_resp_i = 0; w_rd_i = 0;
    check("w512_resp", w_resp_o, 1'b1);
    check("w512_line", w_line_o, exp512);

    // 256/32 fill: 5-bit alignment and eight-beat ordering.
    n_addr_i = 32'h0000_1FFF;
    n_rd_i = 1;
    @(posedge clk);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b == 0) check("n32_addr", n_addr_o, 32'h0000_1FE0);
      n_resp_i = 1; n_burst_i = 32'hC0DE_0000 + 32'(b);
    end
    @(negedge clk);
    n_resp_i = 0; n_rd_i = 0;
    check("n32_resp", n_resp_o, 1'b1);
    check("n32_line", n_line_o, {32'hC0DE_0007, 32'hC0DE_0006, 32'hC0DE_0005, 32'hC0DE_0004,
                                 32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000});
    @(negedge clk);

    // 256/32 evict: word order on burst_o.
    exp256 = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
              32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0F00};
    n_line_i = exp256;
    n_wb_addr_i = 32'h0000_2021;
    n_wr_i = 1;
    @(posedge clk);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      check($sformatf("n32_wb_beat%0d", b), {n_wr_o, n_burst_o}, {1'b1, exp256[b*32 +: 32]});
      if (b == 0) check("n32_wb_addr", n_addr_o, 32'h0000_2020);
      n_resp_i = 1;
    end
    @(negedge clk);
    n_resp_i = 0; n_wr_i = 0;
    check("n32_wb_resp", {n_resp_o, n_wr_o}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
